// File: rtl/pic_pkg.sv
// Shared definitions for the interrupt-acknowledge sequencer and PIC-side blocks.
package pic_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    GAP  = 3'd2,
    P2   = 3'd3,
    HOLD = 3'd4
  } state_t;

  localparam logic INTA_ACTIVE = 1'b0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pic_cycle_timer.sv
// Loadable down-counter; o_done marks the final cycle of a loaded interval.
module pic_cycle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_count;

  // Parks at zero between intervals so it can never wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_done = (r_count == W'(1));

endmodule

// File: rtl/inta_sequencer.sv
// CPU-side 8259 interrupt-acknowledge initiator: two INTA pulses, vector capture,
// and a valid/ack handoff to the core.
//
// state | meaning
// IDLE  | waiting for INT & intEnable with no unconsumed vector
// P1    | first INTA pulse, bus locked
// GAP   | INTA high between pulses, bus still locked
// P2    | second INTA pulse; vector sampled on its last edge
// HOLD  | vector valid, waiting for vectorAck
module inta_sequencer
  import pic_pkg::*;
#(
  parameter int PULSE_WIDTH = 2,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       INT,
  input  logic       intEnable,
  input  logic [7:0] dataBus,
  input  logic       vectorAck,
  output logic       INTA,
  output logic       currentPulse,
  output logic       lockOut,
  output logic       busy,
  output logic [7:0] vector,
  output logic       vectorValid
);

  localparam int CW = $clog2(max_int(PULSE_WIDTH, GAP_CYCLES) + 1);

  state_t        r_state;
  state_t        w_next;
  logic          w_load;
  logic [CW-1:0] w_load_val;
  logic          w_done;

  logic          r_inta;
  logic          r_current_pulse;
  logic          r_lock;
  logic          r_busy;
  logic [7:0]    r_vector;
  logic          r_vector_valid;

  pic_cycle_timer #(.W(CW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = CW'(PULSE_WIDTH);
    case (r_state)
      IDLE: if (INT && intEnable && !r_vector_valid) begin
        w_next = P1;
        w_load = 1'b1;
      end
      P1: if (w_done) begin
        w_next     = GAP;
        w_load     = 1'b1;
        w_load_val = CW'(GAP_CYCLES);
      end
      GAP: if (w_done) begin
        w_next = P2;
        w_load = 1'b1;
      end
      P2:   if (w_done) w_next = HOLD;
      HOLD: if (vectorAck) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_inta          <= ~INTA_ACTIVE;
      r_current_pulse <= 1'b0;
      r_lock          <= 1'b0;
      r_busy          <= 1'b0;
      r_vector        <= 8'h00;
      r_vector_valid  <= 1'b0;
    end else begin
      r_state         <= w_next;
      r_inta          <= ((w_next == P1) || (w_next == P2)) ? INTA_ACTIVE : ~INTA_ACTIVE;
      r_current_pulse <= (w_next == P1);
      r_lock          <= (w_next == P1) || (w_next == GAP) || (w_next == P2);
      r_busy          <= (w_next != IDLE);
      if ((r_state == P2) && w_done) begin
        r_vector       <= dataBus;
        r_vector_valid <= 1'b1;
      end else if ((r_state == HOLD) && vectorAck) begin
        r_vector_valid <= 1'b0;
      end
    end
  end

  assign INTA         = r_inta;
  assign currentPulse = r_current_pulse;
  assign lockOut      = r_lock;
  assign busy         = r_busy;
  assign vector       = r_vector;
  assign vectorValid  = r_vector_valid;

endmodule
